// File: rtl/uart_receiver.sv
// 16x oversampled UART receive stage (8N1) with a one-entry valid/ready holding
// register and single-cycle framing / overrun error pulses.
module uart_receiver #(
   parameter int SMPL_N      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] baud_div_i,
   input  logic        rx_i,
   output logic [7:0]  data_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        frame_err_o,
   output logic        overrun_o,
   output logic        busy_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   localparam logic [3:0] SMPL_LAST = 4'(SMPL_N - 1);
   localparam logic [3:0] SMPL_V0   = 4'(SMPL_N / 2 - 1);
   localparam logic [3:0] SMPL_V1   = 4'(SMPL_N / 2);
   localparam logic [3:0] SMPL_V2   = 4'(SMPL_N / 2 + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxp_q;
   logic [1:0]             state_q, state_d;
   logic [15:0]            div_q, div_d;
   logic [15:0]            baud_q, baud_d;
   logic [3:0]             smpl_q, smpl_d;
   logic                   v0_q, v0_d, v1_q, v1_d;
   logic [2:0]             bitcnt_q, bitcnt_d;
   logic [7:0]             sh_q, sh_d;
   logic [7:0]             data_q, data_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic                   ovr_q, ovr_d;

   logic rx_s, start_edge, tick, vote, bnd, maj, done;

   assign rx_s       = sync_q[SYNC_STAGES-1];
   assign start_edge = (state_q == S_IDLE) && rxp_q && !rx_s;
   assign tick       = (baud_q == 16'd0);
   assign vote       = tick && (smpl_q == SMPL_V2);
   assign bnd        = tick && (smpl_q == SMPL_LAST);
   assign maj        = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      baud_d   = baud_q;
      smpl_d   = smpl_q;
      v0_d     = v0_q;
      v1_d     = v1_q;
      bitcnt_d = bitcnt_q;
      sh_d     = sh_q;
      data_d   = data_q;
      valid_d  = valid_q;
      ferr_d   = 1'b0;
      ovr_d    = 1'b0;
      done     = 1'b0;

      // Divider is only latched at a start edge so mid-frame changes are ignored.
      if (start_edge) begin
         div_d  = baud_div_i;
         baud_d = baud_div_i;
         smpl_d = 4'd0;
      end else if (tick) begin
         baud_d = div_q;
         smpl_d = smpl_q + 4'd1;
      end else begin
         baud_d = baud_q - 16'd1;
      end

      if (tick && smpl_q == SMPL_V0) v0_d = rx_s;
      if (tick && smpl_q == SMPL_V1) v1_d = rx_s;

      case (state_q)
         S_IDLE: if (start_edge) state_d = S_START;
         S_START: begin
            if (vote && maj) begin
               state_d = S_IDLE;
            end else if (bnd) begin
               state_d  = S_DATA;
               bitcnt_d = 3'd7;
            end
         end
         S_DATA: begin
            if (vote) sh_d = {maj, sh_q[7:1]};
            if (bnd) begin
               if (bitcnt_q == 3'd0) state_d = S_STOP;
               else                  bitcnt_d = bitcnt_q - 3'd1;
            end
         end
         default: begin
            // Leave at mid-stop so the next start edge is caught with margin.
            if (vote) begin
               state_d = S_IDLE;
               done    = maj;
               ferr_d  = !maj;
            end
         end
      endcase

      if (done) begin
         if (!valid_q || ready_i) begin
            data_d  = sh_q;
            valid_d = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q   <= '1;
         rxp_q    <= 1'b1;
         state_q  <= S_IDLE;
         div_q    <= 16'd0;
         baud_q   <= 16'd0;
         smpl_q   <= 4'd0;
         v0_q     <= 1'b1;
         v1_q     <= 1'b1;
         bitcnt_q <= 3'd0;
         sh_q     <= 8'h00;
         data_q   <= 8'h00;
         valid_q  <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], rx_i};
         rxp_q    <= rx_s;
         state_q  <= state_d;
         div_q    <= div_d;
         baud_q   <= baud_d;
         smpl_q   <= smpl_d;
         v0_q     <= v0_d;
         v1_q     <= v1_d;
         bitcnt_q <= bitcnt_d;
         sh_q     <= sh_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign frame_err_o = ferr_q;
   assign overrun_o   = ovr_q;
   assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of whole frames plus hand-written
// false-start, overrun and mid-frame reset sequences.
module tb_uart_receiver;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [15:0] baud_div;
   logic        rx_i;
   logic [7:0]  data_o;
   logic        valid_o;
   logic        ready_i;
   logic        frame_err_o;
   logic        overrun_o;
   logic        busy_o;

   always #5 clk = ~clk;

   uart_receiver #(.SMPL_N(16), .SYNC_STAGES(2)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_ni),
      .baud_div_i (baud_div),
      .rx_i       (rx_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .frame_err_o(frame_err_o),
      .overrun_o  (overrun_o),
      .busy_o     (busy_o)
   );

   // Event counters; tests compare deltas across a sequence.
   int         hs_cnt = 0;
   int         ferr_cnt = 0;
   int         ovr_cnt = 0;
   logic [7:0] last_data = 8'h00;

   always @(negedge clk) begin
      if (valid_o && ready_i) begin
         hs_cnt    <= hs_cnt + 1;
         last_data <= data_o;
      end
      if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
      if (overrun_o)   ovr_cnt  <= ovr_cnt + 1;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   // Drives one frame slot per clock from the negedge. Slots g0/g1 are forced
   // low; at slot abort_at reset is pulsed and the frame is abandoned.
   task automatic send_frame(input logic [7:0] d, input logic stp, input int div,
                             input int g0, input int g1, input int abort_at);
      int   bt;
      int   b;
      logic v;
      bt       = 16 * (div + 1);
      baud_div = 16'(div);
      for (int s = 0; s < 10 * bt; s++) begin
         if (s == abort_at) begin
            rst_ni = 1'b0;
            rx_i   = 1'b1;
            repeat (3) @(negedge clk);
            rst_ni = 1'b1;
            return;
         end
         b = s / bt;
         if (b == 0)      v = 1'b0;
         else if (b <= 8) v = d[b-1];
         else             v = stp;
         if (s == g0 || s == g1) v = 1'b0;
         rx_i = v;
         @(negedge clk);
      end
      rx_i = 1'b1;
      repeat (2 * bt) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] d;
      logic       stp;
      int         div;
      int         g0;
      int         g1;
      int         hs;
      int         fe;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int h0, f0, o0;

      // Glitch slots for div=0: sample k of frame bit b is taken from slot 16*b+k+1.
      tbl[0] = '{8'hA5, 1'b1, 3, -1, -1, 1, 0, 8'hA5};
      tbl[1] = '{8'h3C, 1'b0, 3, -1, -1, 0, 1, 8'h00};
      tbl[2] = '{8'h81, 1'b1, 3, -1, -1, 1, 0, 8'h81};
      tbl[3] = '{8'hFF, 1'b1, 0, 25, -1, 1, 0, 8'hFF};
      tbl[4] = '{8'hFF, 1'b1, 0, 24, 25, 1, 0, 8'hFE};
      tbl[5] = '{8'h00, 1'b1, 1, -1, -1, 1, 0, 8'h00};
      tbl[6] = '{8'h55, 1'b1, 2, -1, -1, 1, 0, 8'h55};

      rst_ni   = 1'b0;
      rx_i     = 1'b1;
      ready_i  = 1'b1;
      baud_div = 16'd0;
      repeat (3) @(negedge clk);
      chk("rst_data",  int'(data_o), 0);
      chk("rst_valid", int'(valid_o), 0);
      chk("rst_ferr",  int'(frame_err_o), 0);
      chk("rst_ovr",   int'(overrun_o), 0);
      chk("rst_busy",  int'(busy_o), 0);
      rst_ni = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         h0 = hs_cnt;
         f0 = ferr_cnt;
         send_frame(tbl[i].d, tbl[i].stp, tbl[i].div, tbl[i].g0, tbl[i].g1, -1);
         chk($sformatf("v%0d_hs", i),   hs_cnt - h0, tbl[i].hs);
         chk($sformatf("v%0d_ferr", i), ferr_cnt - f0, tbl[i].fe);
         chk($sformatf("v%0d_busy", i), int'(busy_o), 0);
         if (tbl[i].hs != 0) chk($sformatf("v%0d_data", i), int'(last_data), int'(tbl[i].exp));
      end

      // False start: 20-clock low pulse is high again by the mid-bit vote.
      h0 = hs_cnt;
      f0 = ferr_cnt;
      baud_div = 16'd3;
      rx_i = 1'b0;
      repeat (20) @(negedge clk);
      chk("fs_busy_mid", int'(busy_o), 1);
      rx_i = 1'b1;
      repeat (60) @(negedge clk);
      chk("fs_busy_end", int'(busy_o), 0);
      chk("fs_hs",       hs_cnt - h0, 0);
      chk("fs_ferr",     ferr_cnt - f0, 0);

      // Overrun: second byte dropped while the first is still held.
      ready_i = 1'b0;
      o0 = ovr_cnt;
      send_frame(8'h11, 1'b1, 1, -1, -1, -1);
      chk("ov_valid1", int'(valid_o), 1);
      chk("ov_data1",  int'(data_o), 8'h11);
      send_frame(8'h22, 1'b1, 1, -1, -1, -1);
      chk("ov_valid2", int'(valid_o), 1);
      chk("ov_data2",  int'(data_o), 8'h11);
      chk("ov_pulses", ovr_cnt - o0, 1);
      ready_i = 1'b1;
      repeat (2) @(negedge clk);
      chk("ov_drain_valid", int'(valid_o), 0);
      chk("ov_drain_data",  int'(data_o), 8'h11);

      // Reset inside data bit 3 of a frame, then a clean frame.
      h0 = hs_cnt;
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      send_frame(8'hC3, 1'b1, 1, -1, -1, 32 * 4);
      chk("ab_valid", int'(valid_o), 0);
      chk("ab_busy",  int'(busy_o), 0);
      chk("ab_data",  int'(data_o), 0);
      rx_i = 1'b1;
      repeat (100) @(negedge clk);
      chk("ab_hs",   hs_cnt - h0, 0);
      chk("ab_ferr", ferr_cnt - f0, 0);
      chk("ab_ovr",  ovr_cnt - o0, 0);
      send_frame(8'h5A, 1'b1, 1, -1, -1, -1);
      chk("ab_next_hs",   hs_cnt - h0, 1);
      chk("ab_next_data", int'(last_data), 8'h5A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
